// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of the register file among N_REQ requesters.
//   Round-robin arbitration, with an optional per-requester lock that keeps
//   ownership for a bounded burst of back-to-back writes. The write enable,
//   address and data to the register file come from registers. The register
//   file samples them on the falling edge of CLK.
//
// Ports
//   CLK         in   clock; all state updates on the rising edge
//   RST_N       in   asynchronous active-low reset
//   req         in   [N_REQ]         requester i has a write pending
//   lock        in   [N_REQ]         requester i wants to keep ownership
//   wr_addr_in  in   [N_REQ*ADDR_W]  packed per-requester register index
//   wr_data_in  in   [N_REQ*DATA_W]  packed per-requester write data
//   ack         out  [N_REQ]         combinational one-hot grant (0 in reset)
//   regWrite    out                  registered write enable
//   wr_addr     out  [ADDR_W]        registered register index
//   wr_data     out  [DATA_W]        registered write data
//   owner       out  [clog2(N_REQ)]  index of the last granted requester
//   busy        out                  high while a locked burst owns the port
module regfile_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   wr_addr_in,
    input  logic [N_REQ*DATA_W-1:0]   wr_data_in,
    output logic [N_REQ-1:0]          ack,
    output logic                      regWrite,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state, state_nxt;
    logic [OW-1:0]     ptr, ptr_nxt, owner_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [OW-1:0]     win;
    logic              found;
    logic [N_REQ-1:0]  grant;
    logic              xfer;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];

    // Unpack the per-requester slices once so the winner can be selected by
    // a plain array index.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = wr_addr_in[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = wr_data_in[gi*DATA_W +: DATA_W];
    end

    // Grant logic: depends only on req, state, owner and ptr, never on the
    // write payload.
    // NOTE: every signal written in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant = '0;
        win   = owner;
        found = 1'b0;
        if (state == OWNED) begin
            grant[owner] = req[owner];
        end else begin
            // First requester at or after ptr, wrapping modulo N_REQ.
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req[OW'((int'(ptr) + k) % N_REQ)]) begin
                    found = 1'b1;
                    win   = OW'((int'(ptr) + k) % N_REQ);
                end
            end
            if (found) grant[win] = 1'b1;
        end
    end

    assign ack  = RST_N ? grant : '0;
    assign xfer = |grant;
    assign busy = (state == OWNED);

    // Next-state logic for the arbiter state, rotation pointer, owner and
    // burst counter.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    owner_nxt = win;
                    ptr_nxt   = (int'(win) == N_REQ - 1) ? '0 : win + OW'(1);
                    if (lock[win] && MAX_BURST > 1) begin
                        state_nxt = OWNED;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            OWNED: begin
                // ptr already points past the owner, so after release the
                // next search starts at another requester.
                if (!req[owner]) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    // The burst limit wins over a still-asserted lock.
                    if (!lock[owner] || int'(cnt) + 1 == MAX_BURST)
                        state_nxt = IDLE;
                end
            end
        endcase
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            owner    <= '0;
            regWrite <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
            if (xfer) begin
                regWrite <= 1'b1;
                wr_addr  <= addr_arr[win];
                wr_data  <= data_arr[win];
            end else begin
                // Address and data hold their last values across gaps.
                regWrite <= 1'b0;
            end
        end
    end

endmodule
